// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN classifier constants and input-unpacker state type
package snn_pkg;

   localparam int IMG_PIXELS = 784;
   localparam int IMG_BYTES  = 98;
   localparam int PIX_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      GAP   = 2'd3
   } rx_unpack_state_t;

endpackage

// File: rtl/img_rx_unpack_if.sv
// rtl/img_rx_unpack_if.sv - byte-in / pixel-write / status bundle of the image unpacker
interface img_rx_unpack_if
   import snn_pkg::*;
#(
   parameter int ADDR_W = PIX_ADDR_W
) ();

   logic [7:0]        rx_data;
   logic              rx_rdy;
   logic              clr_rdy;
   logic              snn_busy;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_data;
   logic              ram_we;
   logic              img_done;
   logic              loading;
   logic              overrun;
   logic              timeout;

   // The unpacker itself
   modport slave (
      input  rx_data, rx_rdy, snn_busy,
      output clr_rdy, ram_addr, ram_data, ram_we, img_done, loading, overrun, timeout
   );

   // Receiver, SNN core and RAM side
   modport master (
      output rx_data, rx_rdy, snn_busy,
      input  clr_rdy, ram_addr, ram_data, ram_we, img_done, loading, overrun, timeout
   );

endinterface

// File: rtl/img_rx_unpack.sv
// rtl/img_rx_unpack.sv - unpacks UART bytes LSB-first into 1-bit image RAM writes
module img_rx_unpack
   import snn_pkg::*;
#(
   parameter int NUM_BYTES   = IMG_BYTES,
   parameter int ADDR_W      = PIX_ADDR_W,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic           clk,
   input  logic           rst_n,
   img_rx_unpack_if.slave bus
);

   localparam int CNT_W = $clog2(NUM_BYTES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_BYTES * 8 - 1);

   rx_unpack_state_t  r_state, w_state_nxt;
   logic [7:0]        r_shreg, w_shreg_nxt;
   logic [2:0]        r_bit_cnt, w_bit_nxt;
   logic [CNT_W-1:0]  r_byte_cnt, w_byte_nxt;
   logic [ADDR_W-1:0] r_pix_addr, w_pix_nxt;
   logic [TO_W-1:0]   r_to_cnt, w_to_nxt;

   logic              r_clr_rdy, w_clr_rdy;
   logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
   logic              r_ram_data, w_ram_data;
   logic              r_ram_we, w_ram_we;
   logic              r_img_done, w_img_done;
   logic              r_loading, w_loading;
   logic              r_overrun, w_overrun;
   logic              r_timeout, w_timeout;

   // A byte still showing rx_rdy the cycle after clr_rdy is the one just consumed
   logic w_take, w_accept, w_reject, w_last_bit, w_to_run, w_to_hit;
   assign w_take     = bus.rx_rdy & ~r_clr_rdy;
   assign w_accept   = (r_state == IDLE) & w_take & ~bus.snn_busy;
   assign w_reject   = (r_state == IDLE) & w_take &  bus.snn_busy;
   assign w_last_bit = (r_bit_cnt == 3'd7);
   assign w_to_run   = (r_state == IDLE) & (r_byte_cnt != '0) & ~bus.rx_rdy;
   assign w_to_hit   = w_to_run & (r_to_cnt == TO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: accept -> 8 write cycles -> back to IDLE, or DONE/GAP after the last byte
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SHIFT;
         SHIFT:   if (w_last_bit) w_state_nxt = (r_byte_cnt == LAST_BYTE) ? DONE : IDLE;
         DONE:    w_state_nxt = GAP;
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath and next values of every registered output
   always_comb begin
      w_shreg_nxt = r_shreg;
      w_bit_nxt   = r_bit_cnt;
      w_byte_nxt  = r_byte_cnt;
      w_pix_nxt   = r_pix_addr;
      w_to_nxt    = r_to_cnt;
      w_clr_rdy   = 1'b0;
      w_ram_addr  = r_ram_addr;
      w_ram_data  = 1'b0;
      w_ram_we    = 1'b0;
      w_img_done  = 1'b0;
      w_timeout   = 1'b0;
      w_overrun   = r_overrun | w_reject;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_shreg_nxt = bus.rx_data;
               w_bit_nxt   = 3'd0;
               w_to_nxt    = '0;
               w_clr_rdy   = 1'b1;
            end else if (w_reject) begin
               w_clr_rdy   = 1'b1;
            end else if (w_to_hit) begin
               w_timeout   = 1'b1;
               w_byte_nxt  = '0;
               w_pix_nxt   = '0;
               w_to_nxt    = '0;
            end else if (w_to_run) begin
               w_to_nxt    = r_to_cnt + 1'b1;
            end
         end
         SHIFT: begin
            w_ram_we    = 1'b1;
            w_ram_data  = r_shreg[0];
            w_ram_addr  = r_pix_addr;
            w_shreg_nxt = {1'b0, r_shreg[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
            w_pix_nxt   = (r_pix_addr == LAST_PIX) ? '0 : r_pix_addr + 1'b1;
            if (w_last_bit) w_byte_nxt = r_byte_cnt + 1'b1;
         end
         DONE: begin
            w_img_done = 1'b1;
            w_byte_nxt = '0;
            w_pix_nxt  = '0;
            w_to_nxt   = '0;
         end
         default: begin
         end
      endcase
      w_loading = (w_byte_nxt != '0) | (w_state_nxt == SHIFT);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_pix_addr <= '0;
         r_to_cnt   <= '0;
         r_clr_rdy  <= 1'b0;
         r_ram_addr <= '0;
         r_ram_data <= 1'b0;
         r_ram_we   <= 1'b0;
         r_img_done <= 1'b0;
         r_loading  <= 1'b0;
         r_overrun  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_shreg    <= w_shreg_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_byte_cnt <= w_byte_nxt;
         r_pix_addr <= w_pix_nxt;
         r_to_cnt   <= w_to_nxt;
         r_clr_rdy  <= w_clr_rdy;
         r_ram_addr <= w_ram_addr;
         r_ram_data <= w_ram_data;
         r_ram_we   <= w_ram_we;
         r_img_done <= w_img_done;
         r_loading  <= w_loading;
         r_overrun  <= w_overrun;
         r_timeout  <= w_timeout;
      end
   end

   assign bus.clr_rdy  = r_clr_rdy;
   assign bus.ram_addr = r_ram_addr;
   assign bus.ram_data = r_ram_data;
   assign bus.ram_we   = r_ram_we;
   assign bus.img_done = r_img_done;
   assign bus.loading  = r_loading;
   assign bus.overrun  = r_overrun;
   assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_img_rx_unpack.sv
// tb/tb_img_rx_unpack.sv - directed self-checking bench for img_rx_unpack
module tb_img_rx_unpack;
   import snn_pkg::*;

   localparam int NB = 98;
   localparam int NP = NB * 8;
   localparam int TO = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   img_rx_unpack_if #(.ADDR_W(10)) bus ();

   img_rx_unpack #(.NUM_BYTES(NB), .ADDR_W(10), .TIMEOUT_CYC(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [9:0] a;
      logic       d;
   } wr_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   wr_t  exp_q[$];
   wr_t  wlog[$];
   logic exp_pix [NP];
   logic mem [NP];
   int   model_bidx = 0;
   int   done_cnt = 0;
   int   to_cnt = 0;
   int   clr_cnt = 0;
   int   last_we_cyc = 0;
   logic prev_w783 = 1'b0;
   logic prev_clr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int kind, input int j);
      case (kind)
         0:       return 8'hA5;
         1:       return 8'h3C;
         2:       return 8'(j * 37 + 11);
         default: return 8'(255 - j);
      endcase
   endfunction

   // Model: byte j of an image puts bit i at pixel 8*j+i; abandoned images restart at byte 0
   task automatic push_byte(input logic [7:0] b);
      wr_t w;
      for (int i = 0; i < 8; i++) begin
         w.a = 10'(model_bidx * 8 + i);
         w.d = b[i];
         exp_q.push_back(w);
         exp_pix[model_bidx * 8 + i] = b[i];
      end
      model_bidx = (model_bidx + 1) % NB;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit keep, input bit expect_write);
      int n;
      if (expect_write) push_byte(b);
      bus.rx_data = b;
      bus.rx_rdy  = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.clr_rdy && n < 300);
      check("clr_rdy_seen", int'(bus.clr_rdy), 1);
      if (!keep) bus.rx_rdy = 1'b0;
   endtask

   task automatic send_stream(input int n, input int kind);
      for (int j = 0; j < n; j++) send_byte(pat(kind, j), j != n - 1, 1'b1);
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         tick();
         n++;
      end
      check("img_done_arrived", done_cnt - d0, 1);
   endtask

   // Compare process: every write against the model, img_done placement, image contents
   always @(negedge clk) begin : compare
      int mism;
      if (!rst_n) begin
         check("outputs_zero_in_reset",
               int'({bus.clr_rdy, bus.ram_we, bus.img_done, bus.loading,
                     bus.overrun, bus.timeout, |bus.ram_addr, bus.ram_data}), 0);
         prev_w783 = 1'b0;
         prev_clr  = 1'b0;
      end else begin
         if (bus.ram_we) begin
            wlog.push_back({bus.ram_addr, bus.ram_data});
            last_we_cyc = cyc;
            check("write_was_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               check("write_addr", int'(bus.ram_addr), int'(exp_q[0].a));
               check("write_data", int'(bus.ram_data), int'(exp_q[0].d));
               void'(exp_q.pop_front());
            end
            if (bus.ram_addr < 10'(NP)) mem[bus.ram_addr] = bus.ram_data;
         end
         check("img_done_after_last_write", int'(bus.img_done), int'(prev_w783));
         if (bus.img_done) begin
            done_cnt++;
            mism = 0;
            for (int k = 0; k < NP; k++) if (mem[k] !== exp_pix[k]) mism++;
            check("image_contents_mismatches", mism, 0);
         end
         if (bus.timeout) to_cnt++;
         if (bus.clr_rdy) begin
            clr_cnt++;
            check("clr_rdy_single_cycle", int'(prev_clr), 0);
         end
         prev_clr  = bus.clr_rdy;
         prev_w783 = bus.ram_we && (bus.ram_addr == 10'(NP - 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0, c0, t0, n, t_clr;
      int seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      bus.rx_data  = 8'h00;
      bus.rx_rdy   = 1'b0;
      bus.snn_busy = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("reset_state_we", int'(bus.ram_we), 0);
      check("reset_state_loading", int'(bus.loading), 0);
      check("reset_state_overrun", int'(bus.overrun), 0);

      // Reset mid-byte, then the next byte writes from address 0
      send_byte(8'h5A, 1'b0, 1'b1);
      repeat (3) tick();
      rst_n = 1'b0;
      exp_q.delete();
      model_bidx = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_we", int'(bus.ram_we), 0);
      check("post_reset_loading", int'(bus.loading), 0);
      wlog.delete();
      send_byte(8'hC3, 1'b0, 1'b1);
      repeat (10) tick();
      check("t1_first_addr", int'(wlog[0].a), 0);
      check("t1_write_count", wlog.size(), 8);
      rst_n = 1'b0;
      exp_q.delete();
      model_bidx = 0;
      tick();
      rst_n = 1'b1;
      tick();

      // Full image of 0xA5 with rx_rdy held; core goes busy right after img_done
      wlog.delete();
      d0 = done_cnt;
      send_byte(pat(0, 0), 1'b1, 1'b1);
      t_clr = cyc;
      for (int j = 1; j < NB; j++) send_byte(pat(0, j), j != NB - 1, 1'b1);
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         tick();
         n++;
      end
      bus.snn_busy = 1'b1;
      check("t2_done_count", done_cnt - d0, 1);
      check("t2_write_count", wlog.size(), NP);
      for (int i = 0; i < 8; i++) check("t2_a5_bit_order", int'(wlog[i].d), seq[i]);
      check("t2_last_addr", int'(wlog[NP-1].a), 783);
      check("t2_accept_to_last_write", last_we_cyc - t_clr + 1, 882);

      // Byte while busy: consumed, discarded, overrun latched
      wlog.delete();
      c0 = clr_cnt;
      send_byte(8'hFF, 1'b0, 1'b0);
      repeat (12) tick();
      check("t3_clr_pulses", clr_cnt - c0, 1);
      check("t3_no_writes", wlog.size(), 0);
      check("t3_overrun_set", int'(bus.overrun), 1);
      bus.snn_busy = 1'b0;
      d0 = done_cnt;
      send_stream(NB, 2);
      wait_done(d0);
      check("t3_first_addr", int'(wlog[0].a), 0);
      check("t3_overrun_sticky", int'(bus.overrun), 1);

      // Byte offered in the GAP cycle waits for IDLE; holding rx_rdy through SHIFT takes it once
      push_byte(8'h81);
      bus.rx_data = 8'h81;
      bus.rx_rdy  = 1'b1;
      tick();
      check("t6_gap_not_consumed", int'(bus.clr_rdy), 0);
      tick();
      check("t6_idle_consumes", int'(bus.clr_rdy), 1);
      c0 = clr_cnt;
      repeat (7) tick();
      bus.rx_rdy = 1'b0;
      tick();
      check("t6_single_clr", clr_cnt - c0, 0);

      // Ten bytes then a stall: one timeout, partial image dropped
      send_stream(9, 3);
      t0 = to_cnt;
      n = 0;
      while (to_cnt == t0 && n < 300) begin
         tick();
         n++;
      end
      check("t4_timeout_latency_in_window", int'(n >= 8 + TO - 3 && n <= 8 + TO + 2), 1);
      repeat (20) tick();
      check("t4_single_timeout", to_cnt - t0, 1);
      check("t4_loading_low", int'(bus.loading), 0);
      check("t4_writes_drained", exp_q.size(), 0);
      model_bidx = 0;
      wlog.delete();
      d0 = done_cnt;
      send_stream(NB, 1);
      wait_done(d0);
      check("t4_restart_addr", int'(wlog[0].a), 0);
      check("t4_write_count", wlog.size(), NP);

      // Bytes 50 cycles apart never time out
      d0 = done_cnt;
      t0 = to_cnt;
      for (int j = 0; j < NB; j++) begin
         send_byte(pat(2, j + 5), 1'b0, 1'b1);
         repeat (50) tick();
      end
      check("t5_spaced_done", done_cnt - d0, 1);
      check("t5_spaced_no_timeout", to_cnt - t0, 0);

      // Reset after byte 40, then a clean image from address 0
      send_stream(40, 0);
      repeat (10) tick();
      check("t5_pre_reset_writes", exp_q.size(), 0);
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      model_bidx = 0;
      tick();
      wlog.delete();
      d0 = done_cnt;
      send_stream(NB, 3);
      wait_done(d0);
      repeat (5) tick();
      check("t5_single_done", done_cnt - d0, 1);
      check("t5_restart_addr", int'(wlog[0].a), 0);
      check("t5_write_count", wlog.size(), NP);
      check("final_no_pending_writes", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/img_rx_unpack.md
Name: img_rx_unpack

Overview:
- Upstream input stage of the SNN classifier.
- Takes the byte stream from the UART receiver: 98 bytes per image, each bit one pixel of a 28x28 binary image.
- Unpacks each byte LSB-first into 1-bit writes to the input-image RAM at addresses 0..783.
- Pulses img_done when a full image is stored, so the SNN core starts classification.
- Refuses new bytes while the core is busy, and resynchronises to the host after an inter-byte timeout.

Parameters:
NUM_BYTES, 98, bytes per image (NUM_BYTES*8 pixels)
ADDR_W, 10, RAM address width; must satisfy 2**ADDR_W >= NUM_BYTES*8
TIMEOUT_CYC, 2000000, idle cycles mid-image before the partial image is discarded

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received byte; valid while rx_rdy=1
rx_rdy  input  1  byte available; held high by the receiver until clr_rdy
clr_rdy  output  1  one-cycle pulse; consumes the current byte
snn_busy  input  1  SNN core classifying; new image bytes are not accepted
ram_addr  output  ADDR_W  pixel write address
ram_data  output  1  pixel value
ram_we  output  1  RAM write enable
img_done  output  1  one-cycle pulse: image complete in RAM
loading  output  1  high while a partial image is held (byte_cnt != 0) or a byte is being written
overrun  output  1  sticky: byte arrived while snn_busy=1
timeout  output  1  one-cycle pulse: partial image discarded

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; byte_cnt=0; pix_addr=0; shift reg=0; timeout counter=0.
- Reset mid-image discards the partial image. No RAM write occurs while rst_n=0.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE, rx_rdy=1, snn_busy=0:
  - latch rx_data into shift reg; pulse clr_rdy; clear bit counter and timeout counter; go SHIFT.
- IDLE, rx_rdy=1, snn_busy=1:
  - pulse clr_rdy (byte discarded); set overrun (sticky until reset); no write; stay IDLE.
- SHIFT (exactly 8 cycles):
  - each cycle ram_we=1, ram_data=shreg[0], ram_addr=pix_addr; shift reg shifts right; pix_addr increments.
  - Byte j bit i therefore lands at address 8*j+i.
  - After the 8th write, byte_cnt increments.
  - If byte_cnt was NUM_BYTES-1: go DONE. Otherwise go IDLE.
  - rx_rdy is ignored in SHIFT; the receiver holds the byte.
- DONE (1 cycle): img_done=1; byte_cnt=0; pix_addr=0; go GAP.
- GAP (1 cycle): no byte accepted, giving the core one cycle to raise snn_busy; go IDLE.
- Throughput: 9 cycles per byte with rx_rdy continuously high (1 accept + 8 writes); a full image takes 882 cycles to the last write.
- img_done rises in the cycle after the final write (address 783).
- Timeout:
  - In IDLE with byte_cnt != 0 and rx_rdy=0, the counter increments each cycle.
  - When it reaches TIMEOUT_CYC-1: pulse timeout; byte_cnt=0; pix_addr=0; counter=0.
  - Pixels already written are left stale and are overwritten by the next image.
  - The counter does not run when byte_cnt=0, in SHIFT/DONE/GAP, or while rx_rdy=1 with snn_busy=1.
- Simultaneous events: timeout expiry in the same cycle as an accepted byte — the accept wins, no timeout.
- Widths: byte_cnt has $clog2(NUM_BYTES+1) bits; timeout counter has $clog2(TIMEOUT_CYC) bits; pix_addr has ADDR_W bits and never exceeds NUM_BYTES*8-1.
- All outputs are registered. clr_rdy and img_done are never high for more than one consecutive cycle.

Decomposition:
- Shared package snn_pkg holds: IMG_PIXELS=784, IMG_BYTES=98, PIX_ADDR_W=10, and the state enum typedef rx_unpack_state_t {IDLE, SHIFT, DONE, GAP}.
- No sub-module. The timeout counter and the bit/byte counters are inline; splitting them out adds no reuse.

Test Plan:
1. Assert rst_n=0 mid-run, then release -> every output is 0, no ram_we, and the next byte writes to address 0.
2. Send 98 bytes of 0xA5 with rx_rdy held high; SNN model asserts snn_busy the cycle after img_done -> exactly 784 writes to addresses 0..783, data repeating 1,0,1,0,0,1,0,1; one img_done pulse one cycle after the write to 783; 882 cycles from first accept to last write.
3. With snn_busy=1, present byte 0xFF -> one clr_rdy pulse, no ram_we, overrun=1 and still 1 after the next complete image; the following image still loads from address 0.
4. With TIMEOUT_CYC=100: send 10 bytes, stall 100 cycles -> single timeout pulse, loading=0. Then send 98 bytes of 0x3C -> writes start at address 0 and img_done fires after 98 bytes, not 88.
5. Bytes spaced 50 cycles apart with TIMEOUT_CYC=100 -> no timeout, normal img_done. Assert rst_n=0 after byte 40, release, send 98 bytes -> writes restart at address 0 and exactly one img_done.
6. Present a byte in the GAP cycle -> it is not consumed until IDLE. Hold rx_rdy through SHIFT -> clr_rdy fires only once per byte.
